// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_pkg
//  Description : Shared constants, state encoding and quadrant-to-sign table
//                for the QPSK mixer stage.
//  Revision    : 1.0  initial release
// ============================================================================
package qpsk_pkg;

    // Default build constants
    localparam int CAR_W       = 8;
    localparam int CARRIER_MID = 100;
    localparam int SPS_LOG2    = 4;
    localparam int OUT_MID     = 2 * CARRIER_MID;

    // Symbol transmit state
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } sym_state_t;

    // Differential quadrant -> {sI, sQ} (1 = negate that carrier).
    // Walks the constellation one quadrant per increment.
    function automatic logic [1:0] quad_to_sign(input logic [1:0] qd);
        logic [1:0] s;
        s = 2'b00;
        case (qd)
            2'd0:    s = 2'b00;
            2'd1:    s = 2'b10;
            2'd2:    s = 2'b11;
            default: s = 2'b01;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_mixer_if
//  Description : Serial bit stream valid/ready handshake into the QPSK mixer.
//                master = bit source, slave = mixer.
//                  bit_in    : serial data bit
//                  bit_valid : bit_in valid
//                  bit_ready : bit accepted on clk when bit_valid & bit_ready
//  Revision    : 1.0  initial release
// ============================================================================
interface qpsk_mixer_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, input bit_ready);
    modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface
`default_nettype wire

// File: rtl/qpsk_dibit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_dibit_buffer
//  Description : Packs accepted serial bits into a dibit. The first accepted
//                bit is the MSB (b0), the second the LSB (b1). Holds off new
//                bits once a full dibit is waiting, until the owner loads it.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                bit_in        serial bit
//                bit_valid     bit_in valid
//                bit_ready     buffer can accept (count < 2)
//                load          consume the full dibit (count -> 0)
//                full          a complete dibit is waiting
//                dibit         {b0, b1}
//  Revision    : 1.0  initial release
// ============================================================================
module qpsk_dibit_buffer (
    input  wire        clk,
    input  wire        rst,
    input  wire        bit_in,
    input  wire        bit_valid,
    output logic       bit_ready,
    input  wire        load,
    output logic       full,
    output logic [1:0] dibit
);

    logic [1:0] r_sr;
    logic [1:0] r_bc;
    logic       w_accept;

    assign bit_ready = (r_bc < 2'd2);
    assign full      = (r_bc == 2'd2);
    assign dibit     = r_sr;
    assign w_accept  = bit_valid & bit_ready;

    // load only happens with a full buffer, when no bit can be accepted,
    // so the two branches never compete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= 2'b00;
            r_bc <= 2'd0;
        end else if (load) begin
            r_bc <= 2'd0;
        end else if (w_accept) begin
            if (r_bc == 2'd0) begin
                r_sr[1] <= bit_in;
                r_bc    <= 2'd1;
            end else begin
                r_sr[0] <= bit_in;
                r_bc    <= 2'd2;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qpsk_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_mixer
//  Description : QPSK modulator stage. Packs a serial bit stream into dibits,
//                holds each dibit for SPS carrier samples and sign-mixes the
//                offset-binary I/Q carriers into one offset-binary sample/clk.
//  Config      : QPSK_DIFF_ENC_EN - differential (DQPSK) encoding through a
//                2-bit quadrant accumulator; undefined = signs straight from
//                the dibit.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                icarrier_in       I carrier sample (offset binary)
//                qcarrier_in       Q carrier sample (offset binary)
//                bs                bit stream handshake (slave side)
//                mod_out           mixed sample, offset binary, mid 2*MID
//                active            a data symbol is being transmitted
//                sym_strobe        1-clk pulse: new symbol loaded
//                underflow         1-clk pulse: boundary with no dibit ready
//  Revision    : 1.0  initial release
// ============================================================================
module qpsk_mixer
    import qpsk_pkg::*;
#(
    parameter int CAR_W       = qpsk_pkg::CAR_W,
    parameter int CARRIER_MID = qpsk_pkg::CARRIER_MID,
    parameter int SPS_LOG2    = qpsk_pkg::SPS_LOG2
) (
    input  wire               clk,
    input  wire               rst,
    input  wire [CAR_W-1:0]   icarrier_in,
    input  wire [CAR_W-1:0]   qcarrier_in,
    qpsk_mixer_if.slave       bs,
    output logic [CAR_W+1:0]  mod_out,
    output logic              active,
    output logic              sym_strobe,
    output logic              underflow
);

    localparam int              MW        = CAR_W + 2;
    localparam logic [MW-1:0]   c_MID     = MW'(CARRIER_MID);
    localparam logic [MW-1:0]   c_OUT_MID = MW'(2 * CARRIER_MID);

    // ------------------------------------------------------------------
    // Sample counter; the boundary is the edge on which sc is all ones,
    // so a freshly loaded symbol governs the sc==0 sample.
    // ------------------------------------------------------------------
    logic [SPS_LOG2-1:0] r_sc;
    logic                w_boundary;

    assign w_boundary = (r_sc == {SPS_LOG2{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) r_sc <= '0;
        else     r_sc <= r_sc + 1'b1;
    end

    // ------------------------------------------------------------------
    // Dibit buffer
    // ------------------------------------------------------------------
    logic       w_load;
    logic       w_full;
    logic [1:0] w_dibit;

    qpsk_dibit_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bs.bit_in),
        .bit_valid (bs.bit_valid),
        .bit_ready (bs.bit_ready),
        .load      (w_load),
        .full      (w_full),
        .dibit     (w_dibit)
    );

    // ------------------------------------------------------------------
    // Symbol / active FSM. The buffer state is sampled before this
    // cycle's accept, so a second bit arriving on a boundary waits for
    // the following boundary.
    // ------------------------------------------------------------------
    sym_state_t r_state, w_state_nxt;
    logic       r_strobe, w_strobe_nxt;
    logic       r_uflow,  w_uflow_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_strobe <= 1'b0;
            r_uflow  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_strobe_nxt;
            r_uflow  <= w_uflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_strobe_nxt = 1'b0;
        w_uflow_nxt  = 1'b0;
        if (w_boundary) begin
            if (w_full) begin
                w_load       = 1'b1;
                w_state_nxt  = ST_ACTIVE;
                w_strobe_nxt = 1'b1;
            end else if (r_state == ST_ACTIVE) begin
                w_state_nxt  = ST_IDLE;
                w_uflow_nxt  = 1'b1;
            end
        end
    end

    assign active     = (r_state == ST_ACTIVE);
    assign sym_strobe = r_strobe;
    assign underflow  = r_uflow;

    // ------------------------------------------------------------------
    // Symbol register -> carrier signs {sI, sQ}
    // ------------------------------------------------------------------
    logic [1:0] w_sign;

`ifdef QPSK_DIFF_ENC_EN
    // Quadrant accumulator survives underflow so phase continuity is
    // preserved across gaps in the data stream.
    logic [1:0] r_qd;

    always_ff @(posedge clk) begin
        if (rst)         r_qd <= 2'd0;
        else if (w_load) r_qd <= r_qd + w_dibit;
    end

    assign w_sign = quad_to_sign(r_qd);
`else
    logic [1:0] r_sym;

    always_ff @(posedge clk) begin
        if (rst)         r_sym <= 2'b00;
        else if (w_load) r_sym <= w_dibit;
    end

    assign w_sign = r_sym;
`endif

    // ------------------------------------------------------------------
    // Mixer datapath. Everything is done modulo 2^MW: each carrier
    // deviation is within +/-MID and the true result lies in 0..4*MID,
    // so the wrapped two's-complement sum is exact.
    // ------------------------------------------------------------------
    logic [MW-1:0] w_di, w_dq, w_ti, w_tq, w_mix;
    logic [MW-1:0] r_mod;

    assign w_di  = {2'b00, icarrier_in} - c_MID;
    assign w_dq  = {2'b00, qcarrier_in} - c_MID;
    assign w_ti  = w_sign[1] ? -w_di : w_di;
    assign w_tq  = w_sign[0] ? -w_dq : w_dq;
    assign w_mix = c_OUT_MID + w_ti + w_tq;

    always_ff @(posedge clk) begin
        if (rst)                       r_mod <= c_OUT_MID;
        else if (r_state == ST_ACTIVE) r_mod <= w_mix;
        else                           r_mod <= c_OUT_MID;
    end

    assign mod_out = r_mod;

endmodule
`default_nettype wire
